// File: rtl/demux8_deser.sv
// demux8_deser: 1-bit to byte receiver; a select counter steers each accepted bit into a fill register.
// Optional DEMUX8_PARITY_EN adds a trailing even-parity slot per frame and a par_err output.
module demux8_deser #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef DEMUX8_PARITY_EN
    output logic       par_err,
`endif
    output logic [2:0] sel
);

`ifdef DEMUX8_PARITY_EN
    localparam int SW = 4;
    localparam logic [SW-1:0] LAST_SEL = 4'd8;
`else
    localparam int SW = 3;
    localparam logic [SW-1:0] LAST_SEL = 3'd7;
`endif

    // Handshake: a bit moves when in_valid && in_ready; a byte moves when
    // out_valid && out_ready. Only the final slot of a frame can be stalled.
    logic [SW-1:0] sel_q, sel_d;
    logic [7:0]    fill_q, fill_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
`ifdef DEMUX8_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    logic          accept;
    logic          write_en;
    logic          complete;
    logic [SW-1:0] slot;
    logic [2:0]    idx;
    logic [7:0]    fill_w;

    assign in_ready = !((sel_q == LAST_SEL) && out_valid_q && !out_ready);

    always_comb begin
        accept      = in_valid && in_ready;
        slot        = in_sof ? '0 : sel_q;
        idx         = MSB_FIRST ? (3'd7 - slot[2:0]) : slot[2:0];
`ifdef DEMUX8_PARITY_EN
        write_en    = accept && (slot != LAST_SEL);
`else
        write_en    = accept;
`endif
        complete    = accept && (slot == LAST_SEL);

        // fill_w already contains the incoming bit so completion can load it directly
        fill_w      = fill_q;
        if (write_en) begin
            fill_w[idx] = in_bit;
        end
        fill_d      = fill_w;

        sel_d       = sel_q;
        if (accept) begin
            sel_d = (slot == LAST_SEL) ? '0 : slot + SW'(1);
        end

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef DEMUX8_PARITY_EN
        par_err_d   = par_err_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (complete) begin
            out_data_d  = fill_w;
            out_valid_d = 1'b1;
`ifdef DEMUX8_PARITY_EN
            par_err_d   = (^fill_q) ^ in_bit;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= '0;
            fill_q      <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
`ifdef DEMUX8_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            sel_q       <= sel_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef DEMUX8_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
`ifdef DEMUX8_PARITY_EN
    assign par_err   = par_err_q;
    // The parity slot is shown as 0 on the 3-bit port
    assign sel       = (sel_q == LAST_SEL) ? 3'd0 : sel_q[2:0];
`else
    assign sel       = sel_q;
`endif

endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser: two instances (LSB-first and MSB-first) share one stimulus stream;
// a frame-level reference model feeds expected-byte queues that a monitor pops on delivery.
module tb_demux8_deser;

`ifdef DEMUX8_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready_l, in_ready_m;
    logic [7:0] out_data_l, out_data_m;
    logic       out_valid_l, out_valid_m;
    logic [2:0] sel_l, sel_m;
    logic       par_err_l, par_err_m;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         bits[$];
    logic       held = 1'b0;
    logic [7:0] exp_l_q[$];
    logic [7:0] exp_m_q[$];
    logic [0:0] exp_p_q[$];

    always #5 clk = ~clk;

    demux8_deser #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready_l), .out_data(out_data_l), .out_valid(out_valid_l),
        .out_ready(out_ready),
`ifdef DEMUX8_PARITY_EN
        .par_err(par_err_l),
`endif
        .sel(sel_l)
    );

    demux8_deser #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready_m), .out_data(out_data_m), .out_valid(out_valid_m),
        .out_ready(out_ready),
`ifdef DEMUX8_PARITY_EN
        .par_err(par_err_m),
`endif
        .sel(sel_m)
    );

`ifndef DEMUX8_PARITY_EN
    assign par_err_l = 1'b0;
    assign par_err_m = 1'b0;
`endif

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        held = 1'b0;
        exp_l_q.delete();
        exp_m_q.delete();
        exp_p_q.delete();
    endtask

    // One clock of stimulus; checks handshake/select outputs against the model, then advances it.
    task automatic step(input logic v, input logic b, input logic sof, input logic ordy,
                        output logic acc);
        logic       exp_ready;
        logic [2:0] exp_sel;
        logic       deliver;
        logic       complete;
        logic [7:0] bl, bm;
        logic       par;
        @(negedge clk);
        in_valid  = v;
        in_bit    = b;
        in_sof    = sof;
        out_ready = ordy;
        #1;
        exp_ready = !((bits.size() == FRAME - 1) && held && !ordy);
        exp_sel   = (bits.size() >= 8) ? 3'd0 : 3'(bits.size());
        chk("in_ready_lsb", 8'(in_ready_l), 8'(exp_ready));
        chk("in_ready_msb", 8'(in_ready_m), 8'(exp_ready));
        chk("sel_lsb", 8'(sel_l), 8'(exp_sel));
        chk("sel_msb", 8'(sel_m), 8'(exp_sel));
        chk("out_valid", 8'({out_valid_l, out_valid_m}), 8'({held, held}));
        acc      = v && exp_ready;
        deliver  = held && ordy;
        complete = 1'b0;
        if (acc) begin
            if (sof) bits.delete();
            bits.push_back(int'(b));
            if (bits.size() == FRAME) begin
                bl  = 8'h00;
                bm  = 8'h00;
                par = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    bl  = bl + 8'(bits[i] << i);
                    bm  = bm + 8'(bits[i] << (7 - i));
                end
                for (int i = 0; i < FRAME; i++) par = par ^ bits[i][0];
                exp_l_q.push_back(bl);
                exp_m_q.push_back(bm);
                exp_p_q.push_back(par);
                bits.delete();
                complete = 1'b1;
            end
        end
        held = complete ? 1'b1 : (deliver ? 1'b0 : held);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 1'b0, 1'b0, ordy, acc);
    endtask

    task automatic send_bit(input logic b, input logic sof, input logic ordy);
        logic acc;
        int   tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            step(1'b1, b, sof, ordy, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_bit_timeout actual=stalled required=accept at %0t", $time);
        end
    endtask

    // Bit i of d goes out i-th; the parity bit (if any) follows.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sof,
                              input logic ordy);
        for (int i = 0; i < FRAME; i++) begin
            send_bit((i < 8) ? d[i] : pbit, sof && (i == 0), ordy);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_sel", 8'({sel_l, sel_m}), 8'h00);
        chk("rst_out_valid", 8'({out_valid_l, out_valid_m}), 8'h00);
        chk("rst_out_data_lsb", out_data_l, 8'h00);
        chk("rst_out_data_msb", out_data_m, 8'h00);
        chk("rst_in_ready", 8'({in_ready_l, in_ready_m}), 8'h03);
        chk("rst_par_err", 8'({par_err_l, par_err_m}), 8'h00);
    endtask

    // Monitor: compare whatever is held against the queue front; pop on delivery.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid_l) begin
            if (exp_l_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte actual=%h required=none at %0t", out_data_l, $time);
            end else begin
                chk("held_data_lsb", out_data_l, exp_l_q[0]);
                chk("held_data_msb", out_data_m, exp_m_q[0]);
`ifdef DEMUX8_PARITY_EN
                chk("held_par_err", 8'({par_err_l, par_err_m}), 8'({exp_p_q[0], exp_p_q[0]}));
`endif
                if (out_ready) begin
                    void'(exp_l_q.pop_front());
                    void'(exp_m_q.pop_front());
                    void'(exp_p_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic acc;
        logic [7:0] tmp;
        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // known byte, consumer always ready
        send_frame(8'h4D, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("dir_4d_lsb", out_data_l, 8'h4D);
        chk("dir_4d_msb", out_data_m, 8'hB2);
`ifdef DEMUX8_PARITY_EN
        chk("dir_par_ok", 8'({par_err_l, par_err_m}), 8'h00);
        send_frame(8'h4D, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("dir_par_bad", 8'({par_err_l, par_err_m}), 8'h03);
        chk("dir_par_bad_data", out_data_l, 8'h4D);
`endif
        idle(1'b1);

        // backpressure: second byte stalls on its final slot
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        tmp = 8'h3C;
        for (int i = 0; i < FRAME - 1; i++) send_bit((i < 8) ? tmp[i] : 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("bp_hold_data", out_data_l, 8'hA5);
        chk("bp_in_ready", 8'({in_ready_l, in_ready_m}), 8'h00);
`ifndef DEMUX8_PARITY_EN
        chk("bp_sel", 8'(sel_l), 8'h07);
`endif
        send_bit((FRAME == 9) ? 1'b0 : tmp[7], 1'b0, 1'b1);
        idle(1'b0);
        chk("bp_new_data", out_data_l, 8'h3C);
        idle(1'b1);
        idle(1'b1);

        // start of frame discards a partial byte
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("sof_data_lsb", out_data_l, 8'hFF);
        chk("sof_data_msb", out_data_m, 8'hFF);

        // asynchronous reset mid-byte with a held byte
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("post_rst_data", out_data_l, 8'hC3);
        idle(1'b1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 4) < 3), acc);
        end

        // drain and confirm nothing left undelivered
        repeat (4) idle(1'b1);
        chk("queue_empty", 8'(exp_l_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux8_deser.md
# demux8_deser

Serial-to-parallel receiver that acts as the demultiplexing counterpart of the team's 8:1 mux-based serializer path. An internal 3-bit select counter steers each accepted serial bit to one of 8 positions in a fill register. Completed bytes move to an output holding register and are delivered over a valid/ready handshake. The block sits between a 1-bit link and byte-wide consumer logic.

## Interface
- MSB_FIRST, default 0, selects bit order: 0 puts the first bit in out_data[0]; 1 puts the first bit in out_data[7].
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_sof  input  1  start of frame, qualified by in_valid; forces the bit to slot 0.
- in_ready  output  1  block accepts a bit this cycle.
- out_data  output  8  assembled byte; stable while out_valid is high.
- out_valid  output  1  out_data holds an undelivered byte.
- out_ready  input  1  consumer takes the byte this cycle.
- sel  output  3  current demux select, which is the slot for the next bit.
- par_err  output  1  present only with DEMUX8_PARITY_EN (see Configuration).

## Operation
- A bit is accepted when in_valid && in_ready. A byte is delivered when out_valid && out_ready.
- Slot index k is taken from sel, or is 0 when in_sof is high. The bit is written to fill[k] when MSB_FIRST=0, and to fill[7-k] when MSB_FIRST=1.
- sel after an accept:
  - k==7: wraps to 0.
  - otherwise: k+1.
- in_sof on a final-slot bit (k==7 with in_sof=0 is not affected) behaves as follows: in_sof restarts the byte at slot 0, discards the partial bits, and sets sel to 1.
- Final bit is accepted (k==7, no in_sof):
  - out_data is loaded with the completed fill word, including the bit being accepted.
  - out_valid is set.
- in_ready = !(sel==7 && out_valid && !out_ready).
  - Backpressure applies only on the final bit.
  - Slots 0–6 fill while the previous byte is still held.
- Simultaneous completion and delivery is allowed: the old byte leaves and the new byte loads in the same edge, and out_valid stays 1.
- Delivery without completion clears out_valid.
- Fill bits not yet written in the current byte keep stale values and are not observable.
- Reset values:
  - sel=0
  - fill=8'h00
  - out_data=8'h00
  - out_valid=0
  - par_err=0
  - in_ready=1 (combinational from reset state)
- Reset mid-byte discards the partial byte and any held byte.

## Timing
- Registered outputs: out_data, out_valid, sel, par_err. in_ready is combinational from sel, out_valid and out_ready.
- Latency: out_valid rises on the clock edge that accepts the 8th bit, so it is visible the cycle after that bit was presented.
- Throughput: 1 bit per cycle with out_ready held high, giving 1 byte every 8 cycles with no bubbles.
- out_data and out_valid must not change while out_valid && !out_ready.
- in_valid=0 cycles hold all state.

## Configuration
- DEMUX8_PARITY_EN defined:
  - Each frame is 9 bits: 8 data bits, then 1 even-parity bit.
  - sel widens internally to a 0..8 count; the sel port stays 3 bits and shows 0 during the parity slot.
  - Completion and the backpressure condition move to the parity slot.
  - par_err is loaded together with out_data as the XOR of the 8 data bits and the parity bit.
  - The byte is delivered even when par_err=1.
  - in_sof behaviour is unchanged.
- DEMUX8_PARITY_EN undefined:
  - 8-bit frames.
  - No par_err port and no parity logic.

## Test plan
- Reset, then stream MSB_FIRST=0 bits 1,0,1,1,0,0,1,0 with out_ready=1. Expect out_data=8'h4D and out_valid=1 for exactly one cycle, with sel returning to 0.
- Same bit stream with MSB_FIRST=1. Expect out_data=8'hB2.
- Hold out_ready=0 and send 15 bits of bytes 8'hA5 then 8'h3C:
  - out_data stays 8'hA5.
  - sel reaches 7 and in_ready drops.
  - Raising out_ready delivers 8'hA5 and accepts the final bit in the same cycle, after which out_data=8'h3C.
- Send 4 bits, then assert in_sof with a new byte 8'hFF. Expect the partial bits to be discarded and out_data=8'hFF after 8 bits counted from the sof bit.
- Assert rst asynchronously mid-byte (sel=5) while out_valid=1. Expect all outputs to return to reset values immediately, and the next 8 bits to form a clean byte.
- With DEMUX8_PARITY_EN:
  - 8'h4D followed by parity bit 0 gives par_err=0.
  - 8'h4D followed by parity bit 1 gives par_err=1 and out_data=8'h4D.
